passcode_writer: RTL and testbench

Programs a new 4-digit lock passcode from the board switches and buttons. The block debounces the buttons, stages BCD digits, and shows them on the multiplexed 7-segment display. On commit it offers the code to the checker FSM through a valid/ack handshake. It is the writer side of the passcode path; the existing checker FSM is the reader that consumes the stored code.

---
 rtl/passcode_writer.sv | 240 ++++++++++++++++++++++++
 tb/tb_passcode_writer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/passcode_writer.sv
// passcode_writer: stages a BCD passcode entered from switches/buttons,
// shows it on a 4-digit multiplexed 7-segment display and offers the
// committed code to the checker over a valid/ack handshake.
//
// Handshake: upd_valid rises the clk after a commit and stays high, with
// code held stable, until upd_ack is sampled high on a rising clk edge;
// that edge completes the transfer. upd_ack while upd_valid is low is
// ignored. A clear press during the offer withdraws it unless upd_ack is
// sampled on the same edge, in which case the transfer completes.
module passcode_writer #(
    parameter int DIGITS   = 4,
    parameter int DB_TICKS = 8,
    parameter int CODE_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [3:0]        sw,
    input  logic              btn_enter,
    input  logic              btn_commit,
    input  logic              btn_clear,
    input  logic              upd_ack,
    output logic [CODE_W-1:0] code,
    output logic              upd_valid,
    output logic [2:0]        cnt,
    output logic              err,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int         DBW      = $clog2(DB_TICKS + 1);
    localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2,
        OFFER = 2'd3
    } state_t;

    // State register is left as a named enum so checkers can bind to it.
    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] stage_q, stage_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic [DBW-1:0]    db_cnt_q [3];
    logic [DBW-1:0]    db_cnt_d [3];

    // Button bundle: bit 0 enter, bit 1 commit, bit 2 clear.
    logic [2:0] btn_raw;
    logic [2:0] press;
    logic       do_clear, do_commit, do_enter;

    assign btn_raw = {btn_clear, btn_commit, btn_enter};

    // Active-low segment pattern for a BCD digit; non-BCD shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Debounce: count consecutive high tick samples; pulse on reaching DB_TICKS.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            press[i]    = 1'b0;
            if (tick) begin
                if (btn_raw[i]) begin
                    if (db_cnt_q[i] != DBW'(DB_TICKS)) begin
                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                    end
                    if (db_cnt_q[i] == DBW'(DB_TICKS - 1)) begin
                        press[i] = 1'b1;
                    end
                end else begin
                    db_cnt_d[i] = '0;
                end
            end
        end
    end

    // At most one action per clk: clear beats commit beats enter.
    always_comb begin
        do_clear  = press[2];
        do_commit = press[1] & ~press[2];
        do_enter  = press[0] & ~press[1] & ~press[2];
    end

    // Entry FSM: staging, commit/offer handshake and error pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        code_d  = code_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (do_enter) begin
                    if (sw <= 4'd9) begin
                        stage_d = {sw, {(CODE_W-4){1'b0}}};
                        cnt_d   = 3'd1;
                        state_d = ENTRY;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (do_commit) begin
                    err_d = 1'b1;
                end
            end
            ENTRY: begin
                if (do_clear) begin
                    cnt_d   = 3'd0;
                    stage_d = '0;
                    state_d = IDLE;
                end else if (do_commit) begin
                    err_d = 1'b1;
                end else if (do_enter) begin
                    if (sw <= 4'd9) begin
                        // Unfilled digits are zero, so OR-ing the shifted nibble appends it.
                        stage_d = stage_q | ({sw, {(CODE_W-4){1'b0}}} >> {cnt_q[1:0], 2'b00});
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == LAST_IDX) begin
                            state_d = FULL;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FULL: begin
                if (do_clear) begin
                    cnt_d   = 3'd0;
                    stage_d = '0;
                    state_d = IDLE;
                end else if (do_commit) begin
                    code_d  = stage_q;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end else if (do_enter) begin
                    err_d = 1'b1;
                end
            end
            OFFER: begin
                // Ack completes delivery even if clear is pressed on the same edge.
                if (upd_ack || do_clear) begin
                    valid_d = 1'b0;
                    cnt_d   = 3'd0;
                    stage_d = '0;
                    state_d = IDLE;
                end else if (do_commit || do_enter) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Display scan: pick the digit for the current slot; registered next clk.
    always_comb begin
        logic [1:0]        pos;
        logic [CODE_W-1:0] stage_sh;
        logic [CODE_W-1:0] code_sh;
        idx_d    = tick ? idx_q + 2'd1 : idx_q;
        an_d     = ~(4'b0001 << idx_q);
        // Slot 0 is the rightmost digit, i.e. the last position entered.
        pos      = ~idx_q;
        stage_sh = stage_q << {pos, 2'b00};
        code_sh  = code_q << {pos, 2'b00};
        if (state_q == OFFER) begin
            seg_d = seg_decode(code_sh[CODE_W-1 -: 4]);
        end else if ({1'b0, pos} < cnt_q) begin
            seg_d = seg_decode(stage_sh[CODE_W-1 -: 4]);
        end else begin
            seg_d = SEG_DASH;
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            stage_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= 2'd0;
            an_q    <= 4'b1110;
            seg_q   <= SEG_DASH;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign code      = code_q;
    assign upd_valid = valid_q;
    assign cnt       = cnt_q;
    assign err       = err_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = 1'b1;

endmodule

// File: tb/tb_passcode_writer.sv
// Testbench for passcode_writer: directed scenarios followed by random
// button/tick/ack traffic, all checked every clk against a queue-based
// behavioural model of the passcode entry rules.
module tb_passcode_writer;
    localparam int DB_TICKS = 8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic [3:0]  sw = 4'd0;
    logic        btn_enter = 1'b0;
    logic        btn_commit = 1'b0;
    logic        btn_clear = 1'b0;
    logic        upd_ack = 1'b0;
    logic [15:0] code;
    logic        upd_valid;
    logic [2:0]  cnt;
    logic        err;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    passcode_writer #(.DIGITS(4), .DB_TICKS(DB_TICKS), .CODE_W(16)) dut (
        .clk(clk), .reset(reset), .tick(tick), .sw(sw),
        .btn_enter(btn_enter), .btn_commit(btn_commit), .btn_clear(btn_clear),
        .upd_ack(upd_ack), .code(code), .upd_valid(upd_valid), .cnt(cnt),
        .err(err), .an(an), .seg(seg), .dp(dp)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_db[3];
    logic [3:0] m_digits[$];
    bit         m_offering;
    logic [15:0] m_code;
    bit         m_valid;
    bit         m_err;
    int         m_scan;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    // Segment pattern built from the list of lit segments (a..g).
    function automatic logic [6:0] seg_of(input int d);
        string      s;
        logic [6:0] r;
        r = 7'h7f;
        case (d)
            0: s = "abcdef";
            1: s = "bc";
            2: s = "abdeg";
            3: s = "abcdg";
            4: s = "bcfg";
            5: s = "acdfg";
            6: s = "acdefg";
            7: s = "abc";
            8: s = "abcdefg";
            9: s = "abcdfg";
            default: s = "g";
        endcase
        for (int i = 0; i < s.len(); i++) begin
            int k;
            k = int'(s[i]) - 97;
            r[k] = 1'b0;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_db[i] = 0;
        m_digits.delete();
        m_offering = 0;
        m_code = 16'h0;
        m_valid = 0;
        m_err = 0;
        m_scan = 0;
        m_an = 4'b1110;
        m_seg = seg_of(-1);
    endtask

    // Advance the model by one clk edge using the inputs present at that edge.
    task automatic model_edge();
        bit raw[3];
        bit pr[3];
        int pos;
        int d;
        bit a_clear, a_commit, a_enter;
        if (reset) begin
            model_reset();
        end else begin
            raw[0] = btn_enter;
            raw[1] = btn_commit;
            raw[2] = btn_clear;
            // display reflects the state before this edge
            pos = 3 - m_scan;
            if (m_offering) d = int'((m_code >> (4 * (3 - pos))) & 16'hF);
            else if (pos < m_digits.size()) d = int'(m_digits[pos]);
            else d = -1;
            m_seg = seg_of(d);
            m_an = 4'hF ^ (4'b0001 << m_scan);
            if (tick) m_scan = (m_scan + 1) % 4;
            for (int i = 0; i < 3; i++) begin
                pr[i] = tick && raw[i] && (m_db[i] == DB_TICKS - 1);
                if (tick) m_db[i] = raw[i] ? ((m_db[i] < DB_TICKS) ? m_db[i] + 1 : DB_TICKS) : 0;
            end
            a_clear  = pr[2];
            a_commit = pr[1] && !pr[2];
            a_enter  = pr[0] && !pr[1] && !pr[2];
            m_err = 0;
            if (m_offering) begin
                if (upd_ack) begin
                    exp_q.push_back(m_code);
                    m_offering = 0;
                    m_valid = 0;
                    m_digits.delete();
                end else if (a_clear) begin
                    m_offering = 0;
                    m_valid = 0;
                    m_digits.delete();
                end else if (a_commit || a_enter) begin
                    m_err = 1;
                end
            end else if (a_clear) begin
                m_digits.delete();
            end else if (a_commit) begin
                if (m_digits.size() == 4) begin
                    m_code = {m_digits[0], m_digits[1], m_digits[2], m_digits[3]};
                    m_valid = 1;
                    m_offering = 1;
                end else begin
                    m_err = 1;
                end
            end else if (a_enter) begin
                if (m_digits.size() == 4 || sw > 4'd9) m_err = 1;
                else m_digits.push_back(sw);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        logic        pre_valid;
        logic [15:0] pre_code;
        pre_valid = upd_valid;
        pre_code  = code;
        @(posedge clk);
        model_edge();
        if (!reset && pre_valid === 1'b1 && upd_ack) begin
            if (exp_q.size() == 0) check_val("deliver_unexpected", pre_valid, 0);
            else check_val("deliver_code", pre_code, exp_q.pop_front());
        end
        #1;
        check_val("upd_valid", upd_valid, m_valid);
        check_val("code", code, m_code);
        check_val("cnt", cnt, m_digits.size());
        check_val("err", err, m_err);
        check_val("an", an, m_an);
        check_val("seg", seg, m_seg);
        check_val("dp", dp, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Hold the selected buttons for exactly one debounce window, then release.
    task automatic press(input bit e, input bit c, input bit k, input logic [3:0] v, input bit ack_last);
        sw = v;
        tick = 1'b1;
        for (int n = 0; n < DB_TICKS; n++) begin
            btn_enter = e;
            btn_commit = c;
            btn_clear = k;
            upd_ack = ack_last && (n == DB_TICKS - 1);
            step();
        end
        btn_enter = 0;
        btn_commit = 0;
        btn_clear = 0;
        upd_ack = 0;
        step();
    endtask

    task automatic enter_digits(input logic [15:0] v, input int n);
        logic [15:0] t;
        t = v;
        for (int i = 0; i < n; i++) begin
            press(1, 0, 0, t[15:12], 0);
            t = t << 4;
        end
    endtask

    // ---------------- stimulus ----------------
    int hold[3];
    bit lvl[3];

    initial begin
        model_reset();
        do_reset();
        check_val("rst_an", an, 4'b1110);
        check_val("rst_seg", seg, 7'b0111111);

        // single digit, long hold gives one press
        tick = 1'b1;
        sw = 4'd7;
        btn_enter = 1'b1;
        repeat (DB_TICKS + 20) step();
        btn_enter = 1'b0;
        step();
        check_val("t1_cnt", cnt, 1);
        press(0, 0, 1, 4'd0, 0);

        // full code, commit, stall ack, then ack
        enter_digits(16'h1234, 4);
        press(0, 1, 0, 4'd0, 0);
        idle(10);
        check_val("t2_code", code, 16'h1234);
        check_val("t2_valid", upd_valid, 1);
        upd_ack = 1'b1;
        step();
        upd_ack = 1'b0;
        check_val("t2_valid_drop", upd_valid, 0);
        check_val("t2_cnt", cnt, 0);

        // incomplete commit and non-BCD enter
        enter_digits(16'h1200, 2);
        press(0, 1, 0, 4'd0, 0);
        check_val("t3_cnt", cnt, 2);
        press(1, 0, 0, 4'hA, 0);
        check_val("t3_cnt_a", cnt, 2);
        press(0, 0, 1, 4'd0, 0);

        // overfull entry, then clear shows dashes
        enter_digits(16'h9876, 4);
        press(1, 0, 0, 4'd5, 0);
        check_val("t4_cnt", cnt, 4);
        press(0, 0, 1, 4'd0, 0);
        idle(8);
        check_val("t4_seg", seg, 7'b0111111);

        // commit+clear same clk, then clear+ack same clk in offer
        enter_digits(16'h1234, 4);
        press(0, 1, 1, 4'd0, 0);
        check_val("t5_valid", upd_valid, 0);
        enter_digits(16'h4321, 4);
        press(0, 1, 0, 4'd0, 0);
        press(0, 0, 1, 4'd0, 1);
        check_val("t5_ack_valid", upd_valid, 0);

        // scan with two digits, then reset during an offer
        enter_digits(16'h3500, 2);
        idle(8);
        enter_digits(16'h0056, 2);
        press(0, 1, 0, 4'd0, 0);
        check_val("t6_valid", upd_valid, 1);
        do_reset();
        check_val("t6_rst_valid", upd_valid, 0);

        // random traffic
        for (int i = 0; i < 3; i++) begin
            hold[i] = 0;
            lvl[i] = 0;
        end
        repeat (3000) begin
            tick = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    int pct;
                    pct = (i == 0) ? 45 : ((i == 1) ? 25 : 8);
                    lvl[i] = ($urandom_range(0, 99) < pct);
                    hold[i] = lvl[i] ? $urandom_range(8, 20) : $urandom_range(1, 8);
                    if (i == 0) sw = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                end
                hold[i]--;
            end
            btn_enter = lvl[0];
            btn_commit = lvl[1];
            btn_clear = lvl[2];
            upd_ack = m_valid ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;
        btn_enter = 0;
        btn_commit = 0;
        btn_clear = 0;
        upd_ack = 0;
        idle(4);
        check_val("exp_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
